// File: rtl/spi_pkg.sv
// Shared SPI frame layout and FSM state encoding for the sensor-style SPI slave and master.
package spi_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned RW_BIT   = 15;
  localparam int unsigned MB_BIT   = 14;
  localparam int unsigned ADDR_MSB = 13;
  localparam int unsigned ADDR_LSB = 8;

  localparam logic [7:0] DEFAULT_ID = 8'hE5;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchroniser for one SPI pin plus single-cycle rise/fall pulses in the clk_i domain.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-3 responder backing a 2^ADDR_W x 8 register file; all SPI pins oversampled in clk_i.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter logic [7:0]  ID_VALUE    = DEFAULT_ID,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  output logic              spi_sdo_oe_o,
  input  logic              upd_valid_i,
  output logic              upd_ready_o,
  input  logic [ADDR_W-1:0] upd_addr_i,
  input  logic [7:0]        upd_data_i,
  output logic              wr_strobe_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              abort_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_sclk_i),
    .q_o    (sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_cs_n_i),
    .q_o    (cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_sdi_i),
    .q_o    (sdi_s),
    .rise_o (sdi_rise),
    .fall_o (sdi_fall)
  );

  // Only edges of sclk/cs_n and the level of sdi drive the protocol.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_lvl, sdi_rise, sdi_fall};

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              rw_q, rw_d;
  logic              mb_q, mb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sdo_q, sdo_d;
  logic              sdo_oe_q, sdo_oe_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              abort_q, abort_d;
  logic [7:0]        regs_q [Depth];
  logic [7:0]        regs_d [Depth];

  logic              byte_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              commit;

  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {shreg_q[6:0], sdi_s};
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign addr_inc  = addr_q + 1'b1;
  assign commit    = (state_q == StData) && !cs_rise && byte_done && !rw_q && (addr_q != '0);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cs_fall) state_d = StCmd;
      StCmd: begin
        if (cs_rise)        state_d = StIdle;
        else if (byte_done) state_d = StData;
      end
      StData: begin
        if (cs_rise)                  state_d = StIdle;
        else if (byte_done && !mb_q)  state_d = StDone;
      end
      StDone: if (cs_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    mb_d        = mb_q;
    addr_d      = addr_q;
    sdo_d       = sdo_q;
    sdo_oe_d    = sdo_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    abort_d     = 1'b0;
    regs_d      = regs_q;

    unique case (state_q)
      StIdle: begin
        sdo_d    = 1'b0;
        sdo_oe_d = 1'b0;
        if (cs_fall) begin
          bit_cnt_d = 3'd0;
          shreg_d   = 8'h00;
        end
      end
      StCmd: begin
        if (cs_rise) begin
          abort_d  = (bit_cnt_q != 3'd0);
          sdo_d    = 1'b0;
          sdo_oe_d = 1'b0;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shreg_d   = rx_byte;
          if (bit_cnt_q == 3'd7) begin
            rw_d   = rx_byte[RW_BIT-ADDR_LSB];
            mb_d   = rx_byte[MB_BIT-ADDR_LSB];
            addr_d = cmd_addr;
            if (rx_byte[RW_BIT-ADDR_LSB]) begin
              shreg_d  = regs_q[cmd_addr];
              sdo_oe_d = 1'b1;
            end
          end
        end
      end
      StData: begin
        if (cs_rise) begin
          abort_d  = (bit_cnt_q != 3'd0);
          sdo_d    = 1'b0;
          sdo_oe_d = 1'b0;
        end else begin
          if (sclk_fall && rw_q) begin
            sdo_d   = shreg_q[7];
            shreg_d = {shreg_q[6:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (!rw_q) shreg_d = rx_byte;
            if (bit_cnt_q == 3'd7) begin
              if (commit) begin
                regs_d[addr_q] = rx_byte;
                wr_strobe_d    = 1'b1;
                wr_addr_d      = addr_q;
                wr_data_d      = rx_byte;
              end
              if (mb_q) begin
                addr_d = addr_inc;
                // Reload samples the pre-update array, so a same-cycle local write is not served.
                if (rw_q) shreg_d = regs_q[addr_inc];
              end else begin
                sdo_d    = 1'b0;
                sdo_oe_d = 1'b0;
              end
            end
          end
        end
      end
      StDone: begin
        sdo_d    = 1'b0;
        sdo_oe_d = 1'b0;
      end
      default: begin
        sdo_d    = 1'b0;
        sdo_oe_d = 1'b0;
      end
    endcase

    // SPI commit blocks the local port that cycle, so the two writes never collide.
    if (upd_valid_i && !commit && (upd_addr_i != '0)) begin
      regs_d[upd_addr_i] = upd_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      rw_q        <= 1'b0;
      mb_q        <= 1'b0;
      addr_q      <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      abort_q     <= 1'b0;
      regs_q      <= '{default: 8'h00};
      regs_q[0]   <= ID_VALUE;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      mb_q        <= mb_d;
      addr_q      <= addr_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      abort_q     <= abort_d;
      regs_q      <= regs_d;
    end
  end

  assign spi_sdo_o    = sdo_q & sdo_oe_q;
  assign spi_sdo_oe_o = sdo_oe_q;
  assign upd_ready_o  = ~commit;
  assign wr_strobe_o  = wr_strobe_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign abort_o      = abort_q;

endmodule
